// File: rtl/sync_frame_ctrl.sv
// Serial frame controller: hunts a sync word on a bit-strobed stream, collects a
// fixed-width payload and presents it on a valid/ready handshake.
// Optional build macro PARITY_CHECK_EN adds an even-parity bit after the payload.
module sync_frame_ctrl #(
    parameter int unsigned      PAT_W = 4,
    parameter logic [PAT_W-1:0] PAT   = 4'b1101,
    parameter int unsigned      PAY_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             bit_en,
    input  logic             din,
    output logic [PAY_W-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             parity_err,
    output logic             busy,
    output logic [1:0]       state
);

    localparam int unsigned CNT_W = $clog2(PAY_W + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHunt = 2'd1,
        StLoad = 2'd2,
        StPar  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PAY_W-1:0]   pay_q, pay_d;
    logic [PAY_W-1:0]   data_out_q;
    logic               valid_q;
    logic               overrun_q;
    logic               parity_err_q;

    logic [PAT_W-1:0]   hist_shift;
    logic [PAY_W-1:0]   pay_shift;
    logic               frame_done;
    logic               frame_bad;
    logic [PAY_W-1:0]   frame_data;

    assign hist_shift = {hist_q[PAT_W-2:0], din};
    assign pay_shift  = (pay_q << 1) | PAY_W'(din);

    // Next-state logic: sync hunting, payload collection and frame completion
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        cnt_d      = cnt_q;
        pay_d      = pay_q;
        frame_done = 1'b0;
        frame_bad  = 1'b0;
        frame_data = pay_q;

        if (!enable) begin
            // Dropping enable abandons any partial frame and sync history
            state_d = StIdle;
            hist_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StHunt;
                end
                StHunt: begin
                    if (bit_en) begin
                        hist_d = hist_shift;
                        if (hist_shift == PAT) begin
                            state_d = StLoad;
                            hist_d  = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                StLoad: begin
                    if (bit_en) begin
                        pay_d = pay_shift;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(PAY_W - 1)) begin
`ifdef PARITY_CHECK_EN
                            state_d = StPar;
`else
                            state_d    = StHunt;
                            hist_d     = '0;
                            frame_done = 1'b1;
                            frame_data = pay_shift;
`endif
                        end
                    end
                end
                StPar: begin
`ifdef PARITY_CHECK_EN
                    if (bit_en) begin
                        state_d = StHunt;
                        hist_d  = '0;
                        // Even parity: payload XOR parity bit must be zero
                        if ((^pay_q ^ din) == 1'b0) begin
                            frame_done = 1'b1;
                        end else begin
                            frame_bad = 1'b1;
                        end
                    end
`else
                    state_d = StIdle;
`endif
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // FSM, history, counter and payload shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            hist_q  <= '0;
            cnt_q   <= '0;
            pay_q   <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            cnt_q   <= cnt_d;
            pay_q   <= pay_d;
        end
    end

    // Output handshake: load on completion when the slot is free or being consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_q   <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            overrun_q    <= 1'b0;
            parity_err_q <= frame_bad;
            if (frame_done) begin
                if (!valid_q || data_ready) begin
                    data_out_q <= frame_data;
                    valid_q    <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && data_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = valid_q;
    assign overrun    = overrun_q;
    assign parity_err = parity_err_q;
    assign busy       = (state_q == StLoad) || (state_q == StPar);
    assign state      = state_q;

endmodule

// File: tb/tb_sync_frame_ctrl.sv
// Directed self-checking bench for sync_frame_ctrl (default parameters).
module tb_sync_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       bit_en;
    logic       din;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic       overrun;
    logic       parity_err;
    logic       busy;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    sync_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bit_en     (bit_en),
        .din        (din),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .parity_err (parity_err),
        .busy       (busy),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_en = 1'b1;
        din    = b;
        tick();
        bit_en = 1'b0;
        din    = 1'b0;
    endtask

    task automatic send_sync();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
    endtask

    // Payload MSB first; data_ready is driven to rdy only on the completing bit
    task automatic send_payload(input logic [7:0] p, input logic rdy);
        for (int i = 7; i >= 1; i--) send_bit(p[i]);
`ifdef PARITY_CHECK_EN
        send_bit(p[0]);
        data_ready = rdy;
        send_bit(^p);
`else
        data_ready = rdy;
        send_bit(p[0]);
`endif
        data_ready = 1'b0;
    endtask

    task automatic consume();
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b1;
        bit_en     = 1'b0;
        din        = 1'b0;
        data_ready = 1'b0;
        tick(); tick(); tick();
        chk("rst_data_out", 32'(data_out), 32'h00);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_to_hunt", 32'(state), 32'd1);

        // Basic frame A5
        send_sync();
        chk("sync_load", 32'(state), 32'd2);
        chk("sync_busy", 32'(busy), 32'd1);
        send_payload(8'hA5, 1'b0);
        chk("f1_valid", 32'(data_valid), 32'd1);
        chk("f1_data", 32'(data_out), 32'hA5);
        chk("f1_state", 32'(state), 32'd1);
        chk("f1_busy", 32'(busy), 32'd0);

        // Overrun: second frame dropped while A5 still pending
        send_sync();
        send_payload(8'h3C, 1'b0);
        chk("ovr_pulse", 32'(overrun), 32'd1);
        chk("ovr_data", 32'(data_out), 32'hA5);
        chk("ovr_valid", 32'(data_valid), 32'd1);
        tick();
        chk("ovr_clear", 32'(overrun), 32'd0);
        chk("ovr_hold", 32'(data_out), 32'hA5);
        consume();
        chk("consume_valid", 32'(data_valid), 32'd0);

        // Back-to-back accept on the completion edge
        send_sync();
        send_payload(8'hA5, 1'b0);
        chk("b2b_first", 32'(data_out), 32'hA5);
        send_sync();
        send_payload(8'h3C, 1'b1);
        chk("b2b_overrun", 32'(overrun), 32'd0);
        chk("b2b_data", 32'(data_out), 32'h3C);
        chk("b2b_valid", 32'(data_valid), 32'd1);
        consume();
        chk("b2b_consumed", 32'(data_valid), 32'd0);

        // Sync robustness: 1,1,1,0,1 matches only on the fifth bit
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        chk("rob_no_match", 32'(state), 32'd1);
        send_bit(1'b1);
        chk("rob_match", 32'(state), 32'd2);
        send_payload(8'hFF, 1'b0);
        chk("rob_data", 32'(data_out), 32'hFF);
        chk("rob_valid", 32'(data_valid), 32'd1);
        consume();

        // Enable drop mid-payload discards the partial frame
        send_sync();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        enable = 1'b0;
        tick();
        chk("en_idle", 32'(state), 32'd0);
        chk("en_no_valid", 32'(data_valid), 32'd0);
        enable = 1'b1;
        tick();
        chk("en_hunt", 32'(state), 32'd1);
        send_sync();
        send_payload(8'h5A, 1'b0);
        chk("en_data", 32'(data_out), 32'h5A);
        chk("en_valid", 32'(data_valid), 32'd1);

        // Handshake still completes while held in IDLE
        enable = 1'b0;
        tick();
        chk("idle_hold_valid", 32'(data_valid), 32'd1);
        chk("idle_hold_data", 32'(data_out), 32'h5A);
        consume();
        chk("idle_consume", 32'(data_valid), 32'd0);
        enable = 1'b1;
        tick();

`ifdef PARITY_CHECK_EN
        // Good parity frame
        send_sync();
        send_payload(8'hA5, 1'b0);
        chk("par_ok_data", 32'(data_out), 32'hA5);
        chk("par_ok_valid", 32'(data_valid), 32'd1);
        chk("par_ok_err", 32'(parity_err), 32'd0);
        consume();
        // Bad parity frame: payload dropped, error pulse only
        send_sync();
        for (int i = 7; i >= 0; i--) send_bit(8'hC3 >> i);
        chk("par_state", 32'(state), 32'd3);
        send_bit(1'b1);
        chk("par_bad_err", 32'(parity_err), 32'd1);
        chk("par_bad_valid", 32'(data_valid), 32'd0);
        chk("par_bad_data", 32'(data_out), 32'hA5);
        chk("par_bad_state", 32'(state), 32'd1);
        chk("par_bad_ovr", 32'(overrun), 32'd0);
        tick();
        chk("par_err_clear", 32'(parity_err), 32'd0);
`else
        chk("no_par_err", 32'(parity_err), 32'd0);
`endif

        // Reset mid-frame drops everything including data_out
        send_sync();
        send_payload(8'h81, 1'b0);
        send_sync();
        send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_valid", 32'(data_valid), 32'd0);
        chk("mid_rst_data", 32'(data_out), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_frame_ctrl.md
Name: sync_frame_ctrl

Overview:
Serial frame controller built around a sync-pattern detector. It samples a 1-bit serial stream on a bit strobe and hunts for a programmable sync word. After a sync match it collects a fixed-width payload and hands it to the parallel side over a valid/ready handshake. It sits between the serial front end (bit sampler) and downstream byte-wide logic.

Parameters:
PAT_W, 4, sync pattern width in bits (2..16)
PAT, 4'b1101, sync pattern; the oldest bit is the MSB
PAY_W, 8, payload width in bits (1..32)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous active-high reset
enable  input  1  0 forces IDLE
bit_en  input  1  sample strobe; din is valid only when bit_en=1
din  input  1  serial data bit
data_out  output  PAY_W  last completed payload; the first received bit is the MSB
data_valid  output  1  data_out holds an unconsumed payload
data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1
overrun  output  1  1-cycle pulse: completed frame dropped because data_valid was still held
parity_err  output  1  1-cycle pulse: parity failure (feature only; tied 0 otherwise)
busy  output  1  1 while in LOAD (or PAR)
state  output  2  IDLE=0, HUNT=1, LOAD=2, PAR=3

Behaviour:
- Reset: state=IDLE, shift history=0, bit counter=0, data_out=0. data_valid, overrun, parity_err and busy are all 0.
- IDLE: leave for HUNT on the first clk with enable=1. Bits are ignored while in IDLE.
- HUNT: on each edge with bit_en=1, history <= {history[PAT_W-2:0], din}.
  - If {history[PAT_W-2:0], din}==PAT, go to LOAD on that same edge, clear the counter and clear the history.
  - state=LOAD is therefore visible the cycle after the last sync bit.
- LOAD: each bit_en edge shifts din into the payload shift register (MSB first) and increments the counter.
  - On the edge of the PAY_W-th bit, the frame completes and state returns to HUNT with history cleared. Overlapping sync with payload is therefore never detected.
- Frame completion with data_valid=0, or with data_valid=1 and data_ready=1 in the same cycle: data_out <= payload and data_valid=1 from the next cycle. No overrun.
- Frame completion with data_valid=1 and data_ready=0: payload dropped, data_out unchanged, overrun=1 for exactly one cycle.
- Handshake: data_valid clears on the edge after valid&&ready, unless a new frame completes on that same edge. data_out must not change while data_valid=1 and data_ready=0.
- enable=0 in any state: go to IDLE on the next edge and discard the partial frame and history. data_valid and data_out are unaffected, so the handshake still completes.
- rst mid-frame: full reset, and a pending data_valid is lost.
- bit_en=0: no state or counter change, except the handshake and enable rules above.
- The counter is sized ceil(log2(PAY_W+1)) and never wraps: it is cleared on entry to LOAD.

Optional Feature:
PARITY_CHECK_EN:
- Defined: after the PAY_W-th payload bit the FSM enters PAR and takes one more bit_en bit as the even-parity bit (XOR of payload and parity must be 0).
  - Parity OK: the frame completes on the parity-bit edge, following the completion/overrun rules above.
  - Parity bad: payload discarded, data_valid/data_out untouched, parity_err=1 for one cycle, return to HUNT. No overrun is flagged for a bad-parity frame.
- Undefined: the PAR state is unreachable, parity_err=0 constantly, and the frame completes on the PAY_W-th bit.

Test Plan:
- Reset/defaults: rst=1 for 3 clks, enable=1 -> data_out=0, data_valid=0, state=IDLE, then HUNT one clk after rst falls.
- Basic frame (defaults, no parity): bits 1,1,0,1 then 1,0,1,0,0,1,0,1 with data_ready=0 -> data_valid=1 one clk after the 8th bit, data_out=8'hA5, state=HUNT.
- Overrun: keep data_ready=0 and send a second frame 1101+8'h3C -> overrun pulses 1 clk, data_out stays 8'hA5. Then assert data_ready for 1 clk -> data_valid=0.
- Back-to-back accept: data_ready=1 on the exact completion cycle of frame 2 (8'h3C) while 8'hA5 is pending -> no overrun, data_out=8'h3C, data_valid stays 1.
- Sync robustness: stream 1,1,1,0,1 then payload 8'hFF -> match on the 5th bit (history 1101), data_out=8'hFF. Toggle enable=0 after the 3rd payload bit -> IDLE, no data_valid, and the next full frame is received correctly.
- PARITY_CHECK_EN: 1101+8'hA5+parity 0 -> data_out=8'hA5. Same frame with parity 1 -> parity_err pulse, data_valid unchanged, state=HUNT.
